regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file for the pipelined datapath; next generation of the single-cycle 64x32 two-port register file. It adds configurable width, depth and read-port count, a same-cycle write-to-read bypass, and a post-reset initialisation sequencer that loads a known pattern one entry per cycle while signalling not-ready. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, register count; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- INIT_PATTERN, 1, 0 = entries cleared to zero; 1 = entry i loaded with i+1
- AW (derived), $clog2(NREGS), address width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*AW  packed read addresses; port p at [p*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data; port p at [p*XLEN +: XLEN]
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- ready  out  1  1 = initialisation finished, writes accepted
- init_busy  out  1  1 = initialisation sequencer active (always equals !ready)

## Operation
- Two states: INIT and RUN. Reset forces INIT with index counter idx = 0.
- INIT: each cycle writes the pattern value to entry idx (0 or idx+1, zero-extended to XLEN), then idx increments. When idx = NREGS-1 is written, the next state is RUN. INIT lasts exactly NREGS cycles.
- During INIT, wr_en is ignored (the write is dropped, not queued), and every rd_data port returns 0.
- RUN: when wr_en=1, wr_data is written to entry wr_addr at the clock edge.
- Reads are combinational from the array. Bypass: in RUN, if wr_en=1 and rd_addr[p] == wr_addr, rd_data[p] = wr_data in the same cycle.
- Multiple read ports may address the same entry; each port independently gets the same value.
- Reset asserted mid-INIT or mid-RUN: next cycle is INIT with idx = 0, and the full sequence restarts. Array contents are not otherwise cleared.

## Timing
- Reset values: ready=0, init_busy=1, rd_data=0 on all ports, idx=0.
- ready rises on the edge that completes the last INIT write, i.e. NREGS cycles after reset deasserts.
- Read latency is 0 cycles (combinational, including bypass). Write latency is 1 edge: a non-bypassed read sees the new value in the following cycle.
- Exactly one write per cycle, from either the sequencer or the write port, never both.

## Configuration
- REGFILE_ZERO_REG_EN defined: entry 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 (no bypass for address 0).
  - INIT also writes 0 to entry 0 regardless of INIT_PATTERN.
- Not defined: entry 0 behaves like every other entry.

## Structure
- Shared package regfile_pkg holds:
  - the state enum {RF_INIT, RF_RUN};
  - the pattern encodings RF_PAT_ZERO=0 and RF_PAT_INDEX=1.
- One sub-module, regfile_init_seq, holds the state register, the idx counter, and the ready flag, and outputs the sequencer write enable, address and data. Array, write mux and read/bypass logic stay in regfile_mp.

## Test plan
- Reset for 2 cycles, then release, defaults (NREGS=32, INIT_PATTERN=1) → ready=0 for exactly 32 cycles, then 1; reading addr 5 returns 6 and addr 31 returns 32.
- RUN, wr_en=1, wr_addr=7, wr_data=0xDEAD with rd_addr port0=7 and port1=7 → both ports show 0xDEAD in the same cycle, and still show it the cycle after with wr_en=0.
- wr_en=1 at cycle 10 of INIT, addr 3, data 0x55 → write dropped; after ready, addr 3 reads 4; rd_data=0 during INIT.
- Reset asserted at INIT cycle 20 → ready stays 0 for 32 more cycles after release; all entries hold the pattern.
- REGFILE_ZERO_REG_EN defined, write 0x1234 to addr 0 → addr 0 reads 0 in the same cycle and the next; undefined → same-cycle bypass 0x1234, then stored 0x1234.
- NRD=4, XLEN=32, NREGS=16, INIT_PATTERN=0 → ready after 16 cycles; all four ports read 0; distinct writes to 1, 2, 3, 15 read back correctly on all ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file: sequencer states and init pattern codes.
package regfile_pkg;

  typedef enum logic [0:0] {RF_INIT, RF_RUN} rf_state_e;

  localparam int unsigned RF_PAT_ZERO  = 0;
  localparam int unsigned RF_PAT_INDEX = 1;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset initialisation sequencer: walks every entry once, then reports ready.
// REGFILE_ZERO_REG_EN forces the pattern value of entry 0 to zero.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NREGS        = 32,
  parameter int unsigned INIT_PATTERN = RF_PAT_INDEX,
  localparam int unsigned AW          = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  output logic            init_busy,
  output logic            seq_we,
  output logic [AW-1:0]   seq_addr,
  output logic [XLEN-1:0] seq_data
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seq_we   = 1'b0;
    seq_addr = idx_q;
    seq_data = '0;
    if (state_q == RF_INIT) begin
      // No array write on a reset edge; the sequence restarts from idx 0 anyway.
      seq_we = !reset;
      if (INIT_PATTERN == RF_PAT_INDEX) begin
        seq_data = XLEN'(idx_q) + XLEN'(1);
      end
`ifdef REGFILE_ZERO_REG_EN
      if (idx_q == '0) begin
        seq_data = '0;
      end
`endif
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(NREGS - 1)) begin
        state_d = RF_RUN;
      end
    end
  end

  assign ready     = (state_q == RF_RUN);
  assign init_busy = !ready;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with same-cycle write bypass and init sequencer.
// Optional REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NREGS        = 32,
  parameter int unsigned NRD          = 2,
  parameter int unsigned INIT_PATTERN = RF_PAT_INDEX,
  localparam int unsigned AW          = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                ready,
  output logic                init_busy
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            seq_we;
  logic [AW-1:0]   seq_addr;
  logic [XLEN-1:0] seq_data;
  logic            wr_ok;

  regfile_init_seq #(
    .XLEN         (XLEN),
    .NREGS        (NREGS),
    .INIT_PATTERN (INIT_PATTERN)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .init_busy (init_busy),
    .seq_we    (seq_we),
    .seq_addr  (seq_addr),
    .seq_data  (seq_data)
  );

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok = ready && wr_en && (wr_addr != '0);
`else
  assign wr_ok = ready && wr_en;
`endif

  // Sequencer and port writes are mutually exclusive: the port is only live in RUN.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      mem_q[seq_addr] <= seq_data;
    end else if (wr_ok && !reset) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rd_addr[p*AW +: AW];

    always_comb begin
      data = mem_q[addr];
      if (!ready) begin
        data = '0;
`ifdef REGFILE_ZERO_REG_EN
      end else if (addr == '0) begin
        data = '0;
`endif
      end else if (wr_ok && (addr == wr_addr)) begin
        data = wr_data;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model plus directed literal checks.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                ready, init_busy;

  logic        reset2;
  logic [15:0] rd_addr2;
  logic [127:0] rd_data2;
  logic        wr_en2;
  logic [3:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic        ready2, init_busy2;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_PATTERN(RF_PAT_INDEX)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready), .init_busy(init_busy)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(16), .NRD(4), .INIT_PATTERN(RF_PAT_ZERO)
  ) dut2 (
    .clk(clk), .reset(reset2), .rd_addr(rd_addr2), .rd_data(rd_data2), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .ready(ready2), .init_busy(init_busy2)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: entry contents plus count of INIT cycles still to run.
  logic [XLEN-1:0] model_mem [NREGS];
  int  init_left = 0;
  bit  started = 1'b0;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit Zero = 1'b1;
`else
  localparam bit Zero = 1'b0;
`endif

  function automatic logic [63:0] pat(input int i);
    if (Zero && i == 0) return 64'd0;
    return 64'(i + 1);
  endfunction

  function automatic logic [63:0] exp_read(input logic [AW-1:0] a);
    if (init_left != 0) return 64'd0;
    if (Zero && a == '0) return 64'd0;
    if (wr_en && a == wr_addr) return wr_data;
    return model_mem[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      init_left = NREGS;
      started = 1'b1;
    end else if (init_left > 0) begin
      model_mem[NREGS-init_left] = pat(NREGS - init_left);
      init_left--;
    end else if (wr_en && !(Zero && wr_addr == '0)) begin
      model_mem[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ready", 64'(ready), 64'(init_left == 0));
      check("init_busy", 64'(init_busy), 64'(init_left != 0));
      for (int p = 0; p < NRD; p++) begin
        check("model_rd", rd_data[p*XLEN +: XLEN], exp_read(rd_addr[p*AW +: AW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] port(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] port2(input int p);
    return rd_data2[p*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [3:0] a2 [4];
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    reset2 = 1'b1; wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
    a2[0] = 4'd1; a2[1] = 4'd2; a2[2] = 4'd3; a2[3] = 4'd15;

    repeat (2) tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(init_busy), 64'd1);
    check("rst_rd", rd_data[63:0], 64'd0);
    reset = 1'b0;

    // INIT length, with a dropped write at INIT cycle 10.
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
      wr_en = 1'b0;
      if (n == 10) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; rd_addr = {5'd3, 5'd3};
        #1;
        check("init_rd_zero", port(0), 64'd0);
      end
    end
    wr_en = 1'b0;
    check("init_len", 64'(n), 64'd32);

    rd_addr = {5'd31, 5'd5};
    #1;
    check("pat_addr5", port(0), 64'd6);
    check("pat_addr31", port(1), 64'd32);
    rd_addr = {5'd3, 5'd3};
    #1;
    check("dropped_wr", port(0), 64'd4);

    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD; rd_addr = {5'd7, 5'd7};
    #1;
    check("bypass_p0", port(0), 64'hDEAD);
    check("bypass_p1", port(1), 64'hDEAD);
    tick();
    wr_en = 1'b0;
    #1;
    check("stored_p0", port(0), 64'hDEAD);
    check("stored_p1", port(1), 64'hDEAD);

    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h1234; rd_addr = {5'd0, 5'd0};
    #1;
    check("addr0_same", port(0), Zero ? 64'd0 : 64'h1234);
    tick();
    wr_en = 1'b0;
    #1;
    check("addr0_next", port(1), Zero ? 64'd0 : 64'h1234);

    for (int c = 0; c < 400; c++) begin
      tick();
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, NREGS - 1));
      wr_data = {$urandom, $urandom};
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 1) == 1) rd_addr[p*AW +: AW] = wr_addr;
        else rd_addr[p*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
      end
    end
    tick();
    wr_en = 1'b0;

    // Reset mid-RUN, then again at INIT cycle 20.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("reinit_len", 64'(n), 64'd32);
    for (int i = 0; i < NREGS; i++) begin
      rd_addr = {AW'(NREGS - 1 - i), AW'(i)};
      #1;
      check("reinit_pat", port(0), (Zero && i == 0) ? 64'd0 : 64'(i + 1));
    end

    // Second configuration: 4 ports, 16 x 32, zero pattern.
    tick();
    reset2 = 1'b0;
    n = 0;
    while (!ready2 && n < 100) begin
      tick();
      n++;
    end
    check("cfg2_init_len", 64'(n), 64'd16);
    rd_addr2 = {4'd15, 4'd9, 4'd4, 4'd1};
    #1;
    for (int p = 0; p < 4; p++) check("cfg2_zero", 64'(port2(p)), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      wr_en2 = 1'b1; wr_addr2 = a2[k]; wr_data2 = 32'hA000_0000 + 32'(k * 17 + 1);
      rd_addr2 = {a2[k], a2[k], a2[k], a2[k]};
      #1;
      for (int p = 0; p < 4; p++) check("cfg2_bypass", 64'(port2(p)), 64'(32'hA000_0000 + 32'(k * 17 + 1)));
    end
    tick();
    wr_en2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_addr2 = {a2[k], a2[k], a2[k], a2[k]};
      #1;
      for (int p = 0; p < 4; p++) check("cfg2_stored", 64'(port2(p)), 64'(32'hA000_0000 + 32'(k * 17 + 1)));
    end
    rd_addr2 = {a2[0], a2[1], a2[2], a2[3]};
    #1;
    for (int p = 0; p < 4; p++) check("cfg2_mixed", 64'(port2(p)), 64'(32'hA000_0000 + 32'((3 - p) * 17 + 1)));

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
